// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared fetch-side types and the PC reset constant
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] TEXT_ADDR = 32'hbfc00000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue : in-order fetch request/response queue, PC stage -> decode
// Optional same-cycle response bypass enabled by defining IFQ_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic [31:0] pc_i,
  output logic        pc_advance_o,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  input  logic        out_ready_i
);

  localparam int                c_AW    = $clog2(DEPTH);
  localparam int                c_PW    = c_AW + 1;
  localparam logic [c_PW:0]     c_DEPTH = (c_PW + 1)'(DEPTH);
  localparam logic [c_PW-1:0]   c_ONE   = c_PW'(1);

  fetch_entry_t    r_entry [DEPTH];
  logic [c_PW-1:0] r_head, r_fill, r_tail, r_drop;

  logic [c_PW-1:0] w_filled, w_pending, w_alloc, w_drop_pend, w_flush_drop;
  logic [c_PW:0]   w_occupancy;
  logic            w_fire, w_resp_keep, w_bypass, w_pop, w_store;

  assign w_filled    = r_fill - r_head;
  assign w_pending   = r_tail - r_fill;
  assign w_alloc     = r_tail - r_head;
  assign w_occupancy = {1'b0, w_alloc} + {1'b0, r_drop};

  assign req_valid_o  = !flush_i && (w_occupancy < c_DEPTH);
  assign req_addr_o   = pc_i;
  assign w_fire       = req_valid_o && req_ready_i;
  assign pc_advance_o = w_fire;

  // A response is kept only when no stale fetches remain ahead of it
  assign w_resp_keep = resp_valid_i && (r_drop == '0) && (w_pending != '0);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = !flush_i && (w_filled == '0) && w_resp_keep;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_valid_o = (!flush_i && (w_filled != '0)) || w_bypass;
  assign out_instr_o = w_bypass ? resp_data_i : r_entry[r_head[c_AW-1:0]].instr;
  assign out_pc_o    = w_bypass ? r_entry[r_fill[c_AW-1:0]].pc
                                : r_entry[r_head[c_AW-1:0]].pc;
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_store     = w_resp_keep && !(w_bypass && out_ready_i);

  // Everything still in flight becomes stale; a response landing now retires one of them
  assign w_drop_pend  = r_drop + w_pending;
  assign w_flush_drop = w_drop_pend
                      - {{(c_PW-1){1'b0}}, (resp_valid_i && (w_drop_pend != '0))};

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
      r_drop <= '0;
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else if (flush_i) begin
      r_head <= r_tail;
      r_fill <= r_tail;
      r_drop <= w_flush_drop;
    end else begin
      if (w_fire) begin
        r_entry[r_tail[c_AW-1:0]].pc <= pc_i;
        r_tail <= r_tail + c_ONE;
      end
      if (resp_valid_i && (r_drop != '0)) begin
        r_drop <= r_drop - c_ONE;
      end
      if (w_store) r_entry[r_fill[c_AW-1:0]].instr <= resp_data_i;
      if (w_resp_keep) r_fill <= r_fill + c_ONE;
      if (w_pop) r_head <= r_head + c_ONE;
    end
  end

`ifndef SYNTHESIS
  always @(posedge Clk) begin
    if (Clr_n) begin
      assert (!(resp_valid_i && (r_drop == '0) && (w_pending == '0)))
        else $error("instr_fetch_queue: response with nothing outstanding");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// tb_instr_fetch_queue : directed bench with a queue-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Clr_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_advance_o, req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        resp_valid_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic [31:0] out_instr_o, out_pc_o;
  logic        out_ready_i = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .pc_i(pc_i), .pc_advance_o(pc_advance_o),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
    .out_ready_i(out_ready_i)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: PCs awaiting data, filled {pc,instr} in order, stale responses to drop
  logic [31:0] m_pend[$];
  logic [31:0] m_fpc[$];
  logic [31:0] m_finstr[$];
  int          m_drop = 0;

  logic [31:0] tb_pc = '0;
  logic        s_ov, s_rv;
  logic [31:0] s_pc, s_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_fpc.delete();
    m_finstr.delete();
    m_drop = 0;
  endtask

  // One clock cycle: apply inputs, compare at negedge, advance the model
  task automatic step(input logic fl, input logic rv, input logic [31:0] rd,
                      input logic rr, input logic ordy);
    bit          exp_rv, exp_byp, exp_ov, fire;
    int          fsz, psz;
    logic [31:0] e_pc, e_instr;
    flush_i = fl; resp_valid_i = rv; resp_data_i = rd;
    req_ready_i = rr; out_ready_i = ordy; pc_i = tb_pc;
    @(negedge Clk);
    fsz = m_fpc.size();
    psz = m_pend.size();
    exp_rv  = !fl && (fsz + psz + m_drop < DEPTH);
    fire    = exp_rv && rr;
    exp_byp = BYP && !fl && (fsz == 0) && (m_drop == 0) && (psz > 0) && rv;
    exp_ov  = (!fl && fsz > 0) || exp_byp;
    chk("req_valid", {31'b0, req_valid_o}, {31'b0, exp_rv});
    chk("pc_advance", {31'b0, pc_advance_o}, {31'b0, fire});
    if (exp_rv) chk("req_addr", req_addr_o, tb_pc);
    chk("out_valid", {31'b0, out_valid_o}, {31'b0, exp_ov});
    if (exp_ov) begin
      e_pc    = (fsz > 0) ? m_fpc[0]    : m_pend[0];
      e_instr = (fsz > 0) ? m_finstr[0] : rd;
      chk("out_pc", out_pc_o, e_pc);
      chk("out_instr", out_instr_o, e_instr);
    end
    s_ov = out_valid_o; s_rv = req_valid_o; s_pc = out_pc_o; s_instr = out_instr_o;
    if (fl) begin
      m_drop = m_drop + psz - ((rv && (m_drop + psz) != 0) ? 1 : 0);
      model_reset_keep_drop();
    end else begin
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (psz > 0) begin
          m_fpc.push_back(m_pend.pop_front());
          m_finstr.push_back(rd);
        end
      end
      if (exp_ov && ordy) begin
        void'(m_fpc.pop_front());
        void'(m_finstr.pop_front());
      end
      if (fire) begin
        m_pend.push_back(tb_pc);
        tb_pc = tb_pc + 32'd4;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset_keep_drop();
    m_pend.delete();
    m_fpc.delete();
    m_finstr.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && (m_fpc.size() + m_pend.size()) > 0; k++)
      step(1'b0, m_pend.size() > 0, 32'h5000_0000 + k, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int pops;
    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_out_instr", out_instr_o, 32'd0);
    chk("rst_out_pc", out_pc_o, 32'd0);
    chk("rst_pc_advance", {31'b0, pc_advance_o}, 32'd0);
    @(posedge Clk); #1;
    Clr_n = 1'b1;
    model_reset();

    // First fetch
    tb_pc = TEXT_ADDR;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("first_req_valid", {31'b0, s_rv}, 32'd1);
    step(1'b0, 1'b1, 32'h24080001, 1'b0, 1'b0);
`ifndef IFQ_BYPASS_EN
    chk("first_nobyp_wait", {31'b0, s_ov}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
`endif
    chk("first_out_valid", {31'b0, s_ov}, 32'd1);
    chk("first_out_pc", s_pc, 32'hbfc00000);
    chk("first_out_instr", s_instr, 32'h24080001);
    drain();

    // Full queue, then a pop re-enables requests one cycle later
    for (int i = 0; i < 5; i++)
      step(1'b0, m_pend.size() > 0, 32'hA000_0000 + i, 1'b1, 1'b0);
    chk("full_req_low", {31'b0, s_rv}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("full_pop_same_cycle", {31'b0, s_rv}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("full_pop_next_cycle", {31'b0, s_rv}, 32'd1);
    drain();

    // Flush with three outstanding, three stale responses dropped
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    tb_pc = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1);
      chk("stale_out_valid", {31'b0, s_ov}, 32'd0);
    end
    chk("stale_drop_dut", {29'b0, dut.r_drop}, 32'd0);
    chk("stale_drop_model", m_drop, 32'd0);

    // Flush coinciding with a response, two pending
    repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'hdeadbeef, 1'b0, 1'b0);
    chk("flush_resp_drop", {29'b0, dut.r_drop}, 32'd1);
    step(1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b0);
    chk("flush_resp_drop_after", {29'b0, dut.r_drop}, 32'd0);

    // Pointer wrap: 20 back-to-back fetches
    tb_pc = TEXT_ADDR;
    pops = 0;
    for (int i = 0; i < 28; i++) begin
      step(1'b0, m_pend.size() > 0, 32'hC000_0000 + i,
           tb_pc < TEXT_ADDR + 32'd80, 1'b1);
      if (s_ov) begin
        chk("wrap_pc_order", s_pc, TEXT_ADDR + 32'(4 * pops));
        pops++;
      end
    end
    chk("wrap_pop_count", pops, 32'd20);

    // Reset mid-operation: two filled, one pending
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1111_0000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1111_0001, 1'b1, 1'b0);
    req_ready_i = 1'b0; resp_valid_i = 1'b0;
    #2;
    Clr_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("midrst_ptrs", {20'b0, dut.r_head, dut.r_fill, dut.r_tail, dut.r_drop}, 32'd0);
    model_reset();
    @(posedge Clk); #1;
    Clr_n = 1'b1;
    tb_pc = TEXT_ADDR;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("midrst_req_valid", {31'b0, s_rv}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch-side request/response queue between the PC register stage and decode. Each cycle it issues an instruction-memory read for the current PC, pulses the PC stage's advance enable on every accepted request, and holds returned instructions with their PCs in an in-order queue until decode consumes them. A flush discards all queued and in-flight fetches so the redirected PC stream starts clean.

## Interface
- DEPTH, 4, queue entries and maximum outstanding fetches; power of two, ≥2
- Clk  in  1  clock, rising edge
- Clr_n  in  1  reset, asynchronous, active-low
- pc_i  in  32  current PC from the PC register stage
- pc_advance_o  out  1  advance enable back to the PC stage; high exactly when a request fires
- req_valid_o  out  1  fetch request valid
- req_addr_o  out  32  fetch address (= pc_i)
- req_ready_i  in  1  memory accepts request
- resp_valid_i  in  1  fetch data valid; memory returns in order, one per request, no backpressure
- resp_data_i  in  32  fetched word
- flush_i  in  1  discard everything (exception/redirect); the new PC appears on pc_i the following cycle
- out_valid_o  out  1  head entry holds an instruction
- out_instr_o  out  32  head instruction
- out_pc_o  out  32  head PC
- out_ready_i  in  1  decode consumes head

## Operation
- Circular entries {pc, instr}; three pointers: head (read), fill (next entry awaiting data), tail (next allocation); each pointer is log2(DEPTH)+1 bits, with the MSB as the wrap bit.
- filled = fill−head; pending = tail−fill; alloc = tail−head ≤ DEPTH.
- drop_cnt (log2(DEPTH)+1 bits): number of in-flight responses to discard.
- Request: req_valid_o = !flush_i && (alloc + drop_cnt < DEPTH). Fire = req_valid_o && req_ready_i. On fire: entry[tail].pc ← pc_i, tail++, pc_advance_o = 1.
- Response: if drop_cnt ≠ 0, discard and decrement drop_cnt; else entry[fill].instr ← resp_data_i, fill++.
- Pop: out_valid_o = (filled ≠ 0) && !flush_i. On out_valid_o && out_ready_i, head++.
- Flush: head, fill, tail ← tail; drop_cnt ← drop_cnt + pending − (1 if a response arrives this cycle and drop_cnt + pending ≠ 0). No request fires and no pop occurs in the flush cycle.
- A response with drop_cnt = 0 and pending = 0 is a protocol error. The assertion is non-synthesised, and the response is ignored.

## Timing
- Reset: all pointers and drop_cnt = 0; entries = 0. out_valid_o = 0, out_instr_o = 0, out_pc_o = 0, pc_advance_o = 0. req_valid_o = 1 once Clr_n deasserts (the queue is empty).
- req_addr_o, req_valid_o and pc_advance_o are combinational from pc_i, pointer state and flush_i.
- Latency without bypass: response in cycle t → out_valid_o in cycle t+1.
- Full: when alloc + drop_cnt = DEPTH, req_valid_o = 0. A pop in the same cycle does not re-enable the request until the next cycle.
- Simultaneous pop and response on the same entry is impossible without bypass, since an entry must be filled before it is popped.
- Reset mid-operation: all state is cleared immediately. Memory must also be reset, because outstanding responses are not tracked across reset.

## Configuration
- IFQ_BYPASS_EN defined: when filled = 0, drop_cnt = 0, pending ≠ 0 and resp_valid_i, the outputs present resp_data_i with entry[fill].pc in the same cycle. If out_ready_i is also high, fill and head both advance and nothing is stored.
- IFQ_BYPASS_EN undefined: the latency is always one cycle, as above.

## Structure
- The shared package (cpu_pkg) holds fetch_entry_t {pc, instr} and the reset constant TEXT_ADDR = 32'hbfc00000 used by the PC stage.
- No sub-modules. Pointer and counter logic and the entry array are in one module; the array is flops, not RAM.

## Test plan
- Reset, then pc_i = 0xbfc00000 with req_ready_i = 1 → req_valid_o = 1 and pc_advance_o = 1 in the first cycle. Response 0x24080001 one cycle later → out_valid_o with out_pc_o = 0xbfc00000, out_instr_o = 0x24080001 the next cycle (the same cycle with IFQ_BYPASS_EN).
- out_ready_i = 0, DEPTH = 4, four requests and responses → req_valid_o drops after the 4th request. One pop → req_valid_o high the cycle after.
- Three requests outstanding, flush_i pulsed, three stale responses (0xdeadbeef) arrive → all three are dropped, out_valid_o stays 0, and drop_cnt returns to 0.
- Flush in the same cycle as a response, with two pending → that response is dropped and drop_cnt = 1 afterward.
- Pointer wrap: 20 back-to-back fetches with out_ready_i = 1 → out_pc_o sequence 0xbfc00000, +4, … in order, with no loss or duplication.
- Clr_n asserted with two entries filled and one pending → out_valid_o = 0 immediately and all pointers = 0.
